max7219_frame_scheduler: RTL and testbench
==========================================

# max7219_frame_scheduler

Sequences and shares the MAX7219 serial link (DIN/CS/SCLK) used by the traffic-light matrix displays. After reset it sends the MAX7219 initialisation words. It then arbitrates round-robin between two display clients, for example the countdown/smiley controller and a diagnostic client. Each granted request becomes one 9-word frame: 8 row words fetched from an external combinational font ROM, plus a shutdown-register word.

## Interface
Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles; legal range 1..255.
- INTENSITY, 4'h8: value written to the MAX7219 intensity register (0x0A).

Ports:
- clk  in  1  system clock (1 MHz nominal)
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock clk
- req0, req1  in  1 each  level frame request from client 0 / client 1
- glyph0, glyph1  in  4 each  glyph index; captured at grant
- en0, en1  in  1 each  display enable; captured at grant
- gnt0, gnt1  out  1 each  one-cycle pulse; request accepted, glyph/en captured
- done0, done1  out  1 each  one-cycle pulse; frame for that client complete
- font_glyph  out  4  glyph index presented to the font ROM
- font_row  out  3  row index presented to the font ROM
- font_data  in  8  combinational ROM row bitmap
- busy  out  1  high whenever state != IDLE
- DIN, CS, SCLK  out  1 each  MAX7219 serial link

## Operation
- States: INIT, IDLE, FRAME, SHUT, GAP. An internal word counter and bit counter run inside each state.
- Reset values:
  - CS=1, SCLK=0, DIN=0.
  - gnt*/done*=0.
  - font_glyph=0, font_row=0.
  - State INIT, so busy=1.
  - Round-robin pointer last=1, so client 0 wins the first tie.
- INIT: sends 0x0F00, 0x0900, {0x0A, 4'h0, INTENSITY}, 0x0B07, 0x0C00 in that order, then goes to IDLE. Requests that arrive during INIT stay pending; they are level-sensitive and are not lost.
- IDLE arbitration at each edge:
  - Only one req high: that client wins.
  - Both high: the client != last wins, and last is updated to the winner.
  - On the winning edge: gntX=1, glyph/en latched, CS driven low for row word 0, state FRAME.
- FRAME: row r = 0..7 sends {8'h0r+1, data}.
  - data = font_data when the latched en=1, else 8'h00.
  - font_glyph = latched glyph; font_row = r. Both are held stable for the whole word.
  - font_data is sampled on the edge where CS falls for that word.
- SHUT: sends {8'h0C, 7'b0, en}.
- When CS rises after the SHUT word: doneX=1 for one cycle, state GAP. After the GAP, state IDLE.
- A client that keeps req high is re-arbitrated after each frame, which gives continuous refresh. A client drops req on gnt to get a single frame.
- Glyph and en changes after grant have no effect until the next grant.

## Timing
- Word format: 16 bits, MSB first.
- Word cycle:
  - CS falls at cycle 0.
  - For each bit, SCLK is low for CLK_DIV cycles, with DIN updated on entering the low phase. SCLK is then high for CLK_DIV cycles.
  - After bit 15's high phase, SCLK returns low and CS rises on the same edge.
  - CS stays high for CLK_DIV cycles (GAP/inter-word) before the next CS fall.
- Word period: 33*CLK_DIV cycles (132 at default).
- Init: 5 words (660 cycles). Frame: 9 words (1188 cycles).
- Grant latency: req high at an IDLE edge gives gnt in the following cycle, and CS is low in that same cycle.
- Earliest next grant: CLK_DIV+1 cycles after done.
- gnt and done are never high in the same cycle.
- Asynchronous reset mid-word:
  - CS goes to 1 and SCLK to 0 immediately; no done pulse.
  - INIT replays from word 0 after release.
  - The interrupted client is not re-granted unless its req is still high.

## Test plan
- Reset release, no requests: exactly 5 CS-low words 0x0F00, 0x0900, 0x0A08, 0x0B07, 0x0C00, each 132 cycles apart; busy falls to 0 after the last gap; DIN/SCLK idle at 0.
- req0 pulsed with glyph0=9, en0=1 and font ROM returning 8'hA0+row: gnt0 next cycle, then words 0x01A0..0x08A7 and 0x0C01; font_row steps 0..7; done0 on the final CS rise.
- req0 and req1 held high together: grant order 0,1,0,1; done pulses alternate; no gnt during busy.
- en1=0, glyph1=3: row words 0x0100..0x0800 then 0x0C00; font_glyph=3 throughout.
- req1 asserted during INIT word 2: held pending; gnt1 on the first IDLE edge after INIT completes.
- rst_n low at bit 7 of row word 4: CS=1 and SCLK=0 within the reset assertion, no done1; after release the full INIT sequence replays before any grant.

Source files
------------

// File: rtl/max7219_frame_scheduler.sv
// Shares one MAX7219 serial link between two display clients: sends the init
// words after reset, then serves round-robin 9-word frames (8 font rows + shutdown).
module max7219_frame_scheduler #(
    parameter int unsigned CLK_DIV   = 4,
    parameter logic [3:0]  INTENSITY = 4'h8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] glyph0,
    input  logic [3:0] glyph1,
    input  logic       en0,
    input  logic       en1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [3:0] font_glyph,
    output logic [2:0] font_row,
    input  logic [7:0] font_data,
    output logic       busy,
    output logic       DIN,
    output logic       CS,
    output logic       SCLK
);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_FRAME = 3'd2;
    localparam logic [2:0] S_SHUT  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] HALF_GAP = 6'd32;

    function automatic logic [15:0] init_word(input logic [2:0] idx);
        logic [15:0] w;
        case (idx)
            3'd0:    w = 16'h0F00;
            3'd1:    w = 16'h0900;
            3'd2:    w = {8'h0A, 4'h0, INTENSITY};
            3'd3:    w = 16'h0B07;
            3'd4:    w = 16'h0C00;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    logic [2:0]  r_state;
    logic [2:0]  r_word;
    logic [5:0]  r_half;
    logic [7:0]  r_div;
    logic [15:0] r_shift;
    logic        r_cs, r_sclk, r_din;
    logic [2:0]  r_row;
    logic [3:0]  r_glyph;
    logic        r_en, r_client, r_last;
    logic        r_gnt0, r_gnt1, r_done0, r_done1;

    logic        w_tick, w_pick0, w_pick1, w_grant, w_start;
    logic [2:0]  w_next_idx;
    logic [7:0]  w_next_addr;
    logic [15:0] w_load_word;
    logic [3:0]  w_font_glyph;

    assign w_tick      = (r_div == DIV_LAST);
    assign w_pick0     = req0 && (!req1 || r_last);
    assign w_pick1     = req1 && (!req0 || !r_last);
    assign w_grant     = (r_state == S_IDLE) && (w_pick0 || w_pick1);
    assign w_next_idx  = r_word + 3'd1;
    assign w_next_addr = {5'd0, w_next_idx} + 8'd1;

    // A new word starts on a grant or at the end of an inter-word gap with more to send.
    always_comb begin
        w_start = 1'b0;
        if (w_grant) begin
            w_start = 1'b1;
        end else if (r_state != S_IDLE && w_tick && r_half == HALF_GAP) begin
            w_start = (r_state == S_FRAME) || (r_state == S_INIT && r_word != 3'd4);
        end else begin
            w_start = 1'b0;
        end
    end

    // Word loaded on the start edge; font_data is sampled here, on the CS fall.
    always_comb begin
        w_load_word = 16'h0000;
        case (r_state)
            S_IDLE:  w_load_word = {8'h01, ((w_pick1 ? en1 : en0) ? font_data : 8'h00)};
            S_INIT:  w_load_word = init_word(w_next_idx);
            S_FRAME: begin
                if (r_word == 3'd7) begin
                    w_load_word = {8'h0C, 7'h00, r_en};
                end else begin
                    w_load_word = {w_next_addr, (r_en ? font_data : 8'h00)};
                end
            end
            default: w_load_word = 16'h0000;
        endcase
    end

    // Row 0 is fetched on the grant edge, so the ROM sees the prospective winner's glyph in IDLE.
    always_comb begin
        w_font_glyph = r_glyph;
        if (r_state == S_IDLE && w_pick1) begin
            w_font_glyph = glyph1;
        end else if (r_state == S_IDLE && w_pick0) begin
            w_font_glyph = glyph0;
        end else begin
            w_font_glyph = r_glyph;
        end
    end

    // Sequencer: arbitration, state flow, word framing and SCLK/DIN bit timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_INIT;
            r_word   <= 3'd7;       // wraps to init word 0 when the post-reset gap ends
            r_half   <= HALF_GAP;
            r_div    <= 8'd0;
            r_shift  <= 16'h0000;
            r_cs     <= 1'b1;
            r_sclk   <= 1'b0;
            r_din    <= 1'b0;
            r_row    <= 3'd0;
            r_glyph  <= 4'd0;
            r_en     <= 1'b0;
            r_client <= 1'b0;
            r_last   <= 1'b1;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            if (r_state == S_IDLE) begin
                r_div <= 8'd0;
                if (w_grant) begin
                    r_gnt0   <= w_pick0;
                    r_gnt1   <= w_pick1;
                    r_client <= w_pick1;
                    r_glyph  <= w_pick1 ? glyph1 : glyph0;
                    r_en     <= w_pick1 ? en1 : en0;
                    r_word   <= 3'd0;
                    r_row    <= 3'd0;
                    r_state  <= S_FRAME;
                    if (req0 && req1) begin
                        r_last <= w_pick1;
                    end else begin
                        r_last <= r_last;
                    end
                end
            end else if (!w_tick) begin
                r_div <= r_div + 8'd1;
            end else begin
                r_div <= 8'd0;
                if (r_half < 6'd31) begin
                    r_half <= r_half + 6'd1;
                    if (r_half[0]) begin
                        r_sclk  <= 1'b0;
                        r_din   <= r_shift[15];
                        r_shift <= {r_shift[14:0], 1'b0};
                    end else begin
                        r_sclk <= 1'b1;
                    end
                end else if (r_half == 6'd31) begin
                    r_half <= HALF_GAP;
                    r_sclk <= 1'b0;
                    r_cs   <= 1'b1;
                    r_din  <= 1'b0;
                    if (r_state == S_SHUT) begin
                        r_state <= S_GAP;
                        r_done0 <= !r_client;
                        r_done1 <= r_client;
                    end else if (r_state == S_FRAME && r_word != 3'd7) begin
                        r_row <= w_next_idx;
                    end
                end else begin
                    case (r_state)
                        S_INIT: begin
                            if (r_word == 3'd4) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_word <= w_next_idx;
                            end
                        end
                        S_FRAME: begin
                            if (r_word == 3'd7) begin
                                r_state <= S_SHUT;
                                r_row   <= 3'd0;
                            end else begin
                                r_word <= w_next_idx;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
            if (w_start) begin
                r_cs    <= 1'b0;
                r_sclk  <= 1'b0;
                r_half  <= 6'd0;
                r_din   <= w_load_word[15];
                r_shift <= {w_load_word[14:0], 1'b0};
            end
        end
    end

    assign gnt0       = r_gnt0;
    assign gnt1       = r_gnt1;
    assign done0      = r_done0;
    assign done1      = r_done1;
    assign font_glyph = w_font_glyph;
    assign font_row   = r_row;
    assign busy       = (r_state != S_IDLE);
    assign DIN        = r_din;
    assign CS         = r_cs;
    assign SCLK       = r_sclk;

endmodule

// File: tb/tb_max7219_frame_scheduler.sv
// Scoreboard bench: stimulus queues expected serial words and gnt/done events;
// independent monitors decode the MAX7219 link and the pulses and compare.
module tb_max7219_frame_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] glyph0 = 4'd0, glyph1 = 4'd0;
    logic       en0 = 1'b0, en1 = 1'b0;
    logic       gnt0, gnt1, done0, done1, busy, DIN, CS, SCLK;
    logic [3:0] font_glyph;
    logic [2:0] font_row;
    logic [7:0] font_data;

    assign font_data = 8'hA0 + {5'd0, font_row};

    max7219_frame_scheduler #(.CLK_DIV(4), .INTENSITY(4'h8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .glyph0(glyph0), .glyph1(glyph1),
        .en0(en0), .en1(en1), .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1), .font_glyph(font_glyph), .font_row(font_row),
        .font_data(font_data), .busy(busy), .DIN(DIN), .CS(CS), .SCLK(SCLK)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    logic [15:0] exp_words[$];
    int          exp_gly[$];
    int          exp_ev[$];     // 0 gnt0, 1 gnt1, 2 done0, 3 done1

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Serial-link monitor: shift DIN on SCLK rise, check the word on CS rise.
    logic        prev_cs = 1'b1, prev_sclk = 1'b0;
    logic [15:0] sh = 16'h0000;
    int          bitcnt = 0, falls = 0;
    int          fall_cyc[$];
    logic [2:0]  row_s;
    logic [3:0]  glyph_s;
    always @(negedge clk) begin
        logic [15:0] w;
        int          g;
        if (!rst_n) begin
            prev_cs = 1'b1; prev_sclk = 1'b0; bitcnt = 0;
        end else begin
            if (prev_cs && !CS) begin
                falls++; fall_cyc.push_back(cyc); bitcnt = 0;
            end
            if (!CS && !prev_sclk && SCLK) begin
                if (bitcnt == 0) begin
                    row_s = font_row; glyph_s = font_glyph;
                end
                sh = {sh[14:0], DIN};
                bitcnt++;
            end
            if (!prev_cs && CS) begin
                if (exp_words.size() == 0) begin
                    chk("word_unexpected", exp_words.size(), 1);
                end else begin
                    w = exp_words.pop_front();
                    g = exp_gly.pop_front();
                    chk("word_bits", bitcnt, 16);
                    chk("word", sh, w);
                    if (g >= 0) begin
                        chk("font_row", row_s, int'(w[15:8]) - 1);
                        chk("font_glyph", glyph_s, g);
                    end
                end
            end
            prev_cs = CS; prev_sclk = SCLK;
        end
    end

    // Event monitor: every gnt/done pulse must match the next queued event.
    bit chk_gap = 1'b0;
    int last_done_cyc = -1;
    always @(negedge clk) begin
        int code;
        if (rst_n && (gnt0 || gnt1 || done0 || done1)) begin
            code = gnt0 ? 0 : gnt1 ? 1 : done0 ? 2 : 3;
            chk("gnt_done_overlap", (gnt0 | gnt1) & (done0 | done1), 0);
            if (exp_ev.size() == 0) chk("event_unexpected", exp_ev.size(), 1);
            else chk("event", code, exp_ev.pop_front());
            if (code >= 2) last_done_cyc = cyc;
            else if (chk_gap && last_done_cyc >= 0) chk("gnt_after_done", cyc - last_done_cyc, 5);
        end
    end

    task automatic push_init();
        exp_words.push_back(16'h0F00); exp_words.push_back(16'h0900);
        exp_words.push_back(16'h0A08); exp_words.push_back(16'h0B07);
        exp_words.push_back(16'h0C00);
        for (int i = 0; i < 5; i++) exp_gly.push_back(-1);
    endtask

    task automatic push_rows(input int g, input logic en, input int n);
        logic [7:0] d;
        for (int r = 0; r < n; r++) begin
            d = en ? (8'hA0 + 8'(r)) : 8'h00;
            exp_words.push_back({8'(r + 1), d});
            exp_gly.push_back(g);
        end
    endtask

    task automatic push_frame(input int g, input logic en);
        push_rows(g, en, 8);
        exp_words.push_back({8'h0C, 7'h00, en});
        exp_gly.push_back(-1);
    endtask

    task automatic wait_busy_low(input int budget, input string nm);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
        chk(nm, busy, 0);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n;
        n = 0;
        while ((busy !== 1'b0 || exp_ev.size() != 0 || exp_words.size() != 0) && n < budget) begin
            @(negedge clk); n++;
        end
        chk(nm, exp_ev.size() + exp_words.size(), 0);
        chk({nm, "_busy"}, busy, 0);
    endtask

    initial begin
        int n, ng, fb;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cs", CS, 1);
        chk("rst_sclk", SCLK, 0);
        chk("rst_din", DIN, 0);
        chk("rst_pulses", {gnt0, gnt1, done0, done1}, 0);
        chk("rst_font_glyph", font_glyph, 0);
        chk("rst_font_row", font_row, 0);
        chk("rst_busy", busy, 1);

        // Init sequence
        push_init();
        fall_cyc.delete();
        rst_n = 1'b1;
        wait_busy_low(1200, "init_busy_fall");
        chk("init_word_count", fall_cyc.size(), 5);
        for (int i = 1; i < fall_cyc.size(); i++)
            chk("init_spacing", fall_cyc[i] - fall_cyc[i-1], 132);
        chk("init_queue_empty", exp_words.size(), 0);
        chk("idle_din_sclk_cs", {DIN, SCLK, CS}, 3'b001);

        // Single frame for client 0; inputs changed after grant must not matter
        glyph0 = 4'd9; en0 = 1'b1;
        push_frame(9, 1'b1);
        exp_ev.push_back(0); exp_ev.push_back(2);
        req0 = 1'b1;
        @(negedge clk);
        chk("gnt0_latency", gnt0, 1);
        chk("cs_low_at_gnt", CS, 0);
        req0 = 1'b0; glyph0 = 4'd2; en0 = 1'b0;
        wait_idle(2000, "frame0_complete");

        // Client 1 with display disabled
        glyph1 = 4'd3; en1 = 1'b0;
        push_frame(3, 1'b0);
        exp_ev.push_back(1); exp_ev.push_back(3);
        req1 = 1'b1;
        n = 0;
        while (gnt1 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("gnt1_seen", gnt1, 1);
        req1 = 1'b0;
        wait_idle(2000, "frame1_complete");

        // Both held: strict alternation, minimum spacing after done
        glyph0 = 4'd9; en0 = 1'b1; glyph1 = 4'd3; en1 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            push_frame(9, 1'b1); push_frame(3, 1'b0);
            exp_ev.push_back(0); exp_ev.push_back(2);
            exp_ev.push_back(1); exp_ev.push_back(3);
        end
        last_done_cyc = -1; chk_gap = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        ng = 0; n = 0;
        while (ng < 4 && n < 8000) begin
            @(negedge clk); n++;
            if (gnt0 || gnt1) ng++;
        end
        chk("four_grants", ng, 4);
        req0 = 1'b0; req1 = 1'b0;
        wait_idle(3000, "rr_complete");
        chk_gap = 1'b0;

        // req1 raised during init word 2 stays pending until IDLE
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        push_init();
        fb = falls;
        rst_n = 1'b1;
        n = 0;
        while (falls < fb + 3 && n < 1000) begin @(negedge clk); n++; end
        chk("init_word2_reached", falls - fb, 3);
        glyph1 = 4'd5; en1 = 1'b1; req1 = 1'b1;
        exp_ev.push_back(1);
        push_rows(5, 1'b1, 4);
        wait_busy_low(1000, "init2_busy_fall");
        chk("gnt1_not_during_init", gnt1, 0);
        fb = falls;
        @(negedge clk);
        chk("gnt1_first_idle_edge", gnt1, 1);
        req1 = 1'b0;

        // Reset in the middle of row word 4
        n = 0;
        while (!(falls == fb + 5 && bitcnt >= 7) && n < 1000) begin @(negedge clk); n++; end
        chk("row4_bit7_reached", falls - fb, 5);
        rst_n = 1'b0;
        #1;
        chk("midreset_cs", CS, 1);
        chk("midreset_sclk", SCLK, 0);
        chk("midreset_done1", done1, 0);
        repeat (3) @(negedge clk);
        chk("midreset_pulses", {gnt0, gnt1, done0, done1}, 0);
        push_init();
        fall_cyc.delete();
        rst_n = 1'b1;
        wait_busy_low(1200, "replay_busy_fall");
        chk("replay_word_count", fall_cyc.size(), 5);
        repeat (20) @(negedge clk);
        chk("final_queues_empty", exp_words.size() + exp_ev.size(), 0);
        chk("final_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
